// File: rtl/imm_encode.sv
// RV32I immediate packer: encodes imm into instr bits [31:7] over a 2-stage valid/ready pipeline.
// Optional error counter enabled by defining IMM_ENCODE_ERRCNT_EN.
module imm_encode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [24:0] base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] instr_hi,
    output logic        range_err,
    output logic        align_err,
    output logic        fmt_err,
    output logic [7:0]  err_count
);

    localparam int unsigned HI_W  = 25;
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] FMT_U = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_I = 3'b011;
    localparam logic [2:0] FMT_J = 3'b100;

    typedef struct packed {
        logic [HI_W-1:0] hi;
        logic            range_err;
        logic            align_err;
        logic            fmt_err;
    } enc_t;

    enc_t enc;
    enc_t s1;
    enc_t s2;
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic accept;

    // Sign-extension checks: upper bits must all equal the format's sign bit
    logic [20:0] top11;
    logic [19:0] top12;
    logic [11:0] top20;
    logic        fits11;
    logic        fits12;
    logic        fits20;

    assign top11  = imm[31:11];
    assign top12  = imm[31:12];
    assign top20  = imm[31:20];
    assign fits11 = (&top11) | ~(|top11);
    assign fits12 = (&top12) | ~(|top12);
    assign fits20 = (&top20) | ~(|top20);

    // Encode from the low imm bits regardless of errors (truncation)
    always_comb begin
        enc.hi        = base;
        enc.range_err = 1'b0;
        enc.align_err = 1'b0;
        enc.fmt_err   = 1'b0;
        case (imm_src)
            FMT_U: begin
                enc.hi[24:5]  = imm[31:12];
                enc.range_err = |imm[11:0];
            end
            FMT_S: begin
                enc.hi[24:18] = imm[11:5];
                enc.hi[4:0]   = imm[4:0];
                enc.range_err = ~fits11;
            end
            FMT_B: begin
                enc.hi[24]    = imm[12];
                enc.hi[23:18] = imm[10:5];
                enc.hi[4:1]   = imm[4:1];
                enc.hi[0]     = imm[11];
                enc.range_err = ~fits12;
                enc.align_err = imm[0];
            end
            FMT_I: begin
                enc.hi[24:13] = imm[11:0];
                enc.range_err = ~fits11;
            end
            FMT_J: begin
                enc.hi[24]    = imm[20];
                enc.hi[23:14] = imm[10:1];
                enc.hi[13]    = imm[11];
                enc.hi[12:5]  = imm[19:12];
                enc.range_err = ~fits20;
                enc.align_err = imm[0];
            end
            default: enc.fmt_err = 1'b1;
        endcase
    end

    assign s1_adv   = ~s2_valid | out_ready;
    assign in_ready = ~s1_valid | s1_adv;
    assign accept   = in_valid & in_ready;

    // Two-entry pipeline; s2 holds while stalled downstream
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1       <= '0;
            s2       <= '0;
        end else begin
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2 <= s1;
                end
            end
            if (accept) begin
                s1_valid <= 1'b1;
                s1       <= enc;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;
    assign instr_hi  = s2.hi;
    assign range_err = s2.range_err;
    assign align_err = s2.align_err;
    assign fmt_err   = s2.fmt_err;

`ifdef IMM_ENCODE_ERRCNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating count of erroneous output handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (s2_valid && out_ready && (s2.range_err || s2.align_err || s2.fmt_err)
                     && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign err_count = cnt;
`else
    assign err_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: directed test-plan vectors, backpressure, streaming, reset and
// randomized traffic checked against an arithmetic reference model via a scoreboard.
module tb_imm_encode;

`ifdef IMM_ENCODE_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  imm_src = 3'd0;
    logic [31:0] imm = 32'd0;
    logic [24:0] base = 25'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [24:0] instr_hi;
    logic        range_err;
    logic        align_err;
    logic        fmt_err;
    logic [7:0]  err_count;

    imm_encode dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .imm(imm), .base(base), .out_valid(out_valid),
        .out_ready(out_ready), .instr_hi(instr_hi), .range_err(range_err),
        .align_err(align_err), .fmt_err(fmt_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: field placement by shift/mask arithmetic, range by signed bounds
    function automatic logic [27:0] model(input logic [2:0] src, input logic [31:0] v,
                                          input logic [24:0] b);
        longint sv;
        logic [31:0] hi;
        bit r, a, f;
        sv = longint'($signed(v));
        hi = 32'(b);
        r = 0; a = 0; f = 0;
        case (src)
            3'd0: begin
                hi = ((v >> 12) << 5) | (32'(b) & 32'h1F);
                r  = (v % 4096) != 0;
            end
            3'd1: begin
                hi = (((v >> 5) & 32'h7F) << 18) | (32'(b) & 32'h3FFE0) | (v & 32'h1F);
                r  = (sv < -2048) || (sv > 2047);
            end
            3'd2: begin
                hi = (((v >> 12) & 32'h1) << 24) | (((v >> 5) & 32'h3F) << 18)
                   | (32'(b) & 32'h3FFE0) | (v & 32'h1E) | ((v >> 11) & 32'h1);
                r  = (sv < -4096) || (sv > 4095);
                a  = (v % 2) != 0;
            end
            3'd3: begin
                hi = ((v & 32'hFFF) << 13) | (32'(b) & 32'h1FFF);
                r  = (sv < -2048) || (sv > 2047);
            end
            3'd4: begin
                hi = (((v >> 20) & 32'h1) << 24) | (((v >> 1) & 32'h3FF) << 14)
                   | (((v >> 11) & 32'h1) << 13) | (((v >> 12) & 32'hFF) << 5)
                   | (32'(b) & 32'h1F);
                r  = (sv < -(64'sd1 << 20)) || (sv > (64'sd1 << 20) - 1);
                a  = (v % 2) != 0;
            end
            default: f = 1;
        endcase
        return {hi[24:0], r, a, f};
    endfunction

    logic [27:0] sb[$];
    int          mdl_cnt = 0;
    bit          mon_on = 0;
    bit          held = 0;
    logic [24:0] held_hi;
    logic [2:0]  held_fl;
    int          cyc = 0;
    int          n_out = 0;
    int          mark = 0;
    int          first_out = 0;
    int          last_out = 0;

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [27:0] e;
        if (mon_on) begin
            check("err_count", 32'(err_count), 32'(mdl_cnt));
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_hi", 32'(instr_hi), 32'(held_hi));
                check("hold_flags", 32'({range_err, align_err, fmt_err}), 32'(held_fl));
            end
            if (reset) begin
                sb.delete();
                mdl_cnt = 0;
                held = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'd0, 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("instr_hi", 32'(instr_hi), 32'(e[27:3]));
                        check("flags", 32'({range_err, align_err, fmt_err}), 32'(e[2:0]));
                        if (CNT_EN && (e[2:0] != 3'b000) && mdl_cnt != 255) mdl_cnt++;
                    end
                    if (n_out == mark) first_out = cyc;
                    last_out = cyc;
                    n_out++;
                end
                if (in_valid && in_ready) sb.push_back(model(imm_src, imm, base));
                held    = out_valid && !out_ready;
                held_hi = instr_hi;
                held_fl = {range_err, align_err, fmt_err};
            end
        end
        cyc++;
    end

    task automatic send(input logic [2:0] s, input logic [31:0] v, input logic [24:0] b);
        bit ok;
        ok = 0;
        imm_src  = s;
        imm      = v;
        base     = b;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return $urandom & 32'hFFFFF000;
            default: return 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
        endcase
    endfunction

    logic [2:0]  d_src[7]  = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd0, 3'd4, 3'd7};
    logic [31:0] d_imm[7]  = '{32'hFFFFF800, 32'h800, 32'hFFFFFFFC, 32'h3, 32'h12345000, 32'h2, 32'h0};
    logic [24:0] d_base[7] = '{25'hABC, 25'hABC, 25'h0, 25'h0, 25'h1F, 25'h0, 25'h155};
    logic [24:0] d_hi[7]   = '{25'h1000ABC, 25'h1000ABC, 25'h1FC001D, 25'h2, 25'h2468BF, 25'h4000, 25'h155};
    logic [2:0]  d_fl[7]   = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b000, 3'b001};

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr_hi", 32'(instr_hi), 32'd0);
        check("rst_flags", 32'({range_err, align_err, fmt_err}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err_count", 32'(err_count), 32'd0);
        mon_on = 1;
        @(posedge clk); #1;

        // Directed vectors with latency check
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(d_src[i], d_imm[i], d_base[i]);
            @(negedge clk);
            check("lat_early", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("lat_valid", 32'(out_valid), 32'd1);
            check("dir_hi", 32'(instr_hi), 32'(d_hi[i]));
            check("dir_flags", 32'({range_err, align_err, fmt_err}), 32'(d_fl[i]));
            @(posedge clk); #1;
        end

        // Backpressure: only two items fit
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            imm_src  = 3'd3;
            imm      = 32'(i + 1);
            base     = 25'(i);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_drained", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;

        // Streaming: back-to-back with no bubbles
        mark = n_out;
        for (int i = 0; i < 10; i++) begin
            imm_src  = 3'($urandom_range(0, 4));
            imm      = rand_imm();
            base     = 25'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stream_count", 32'(n_out - mark), 32'd10);
        check("stream_span", 32'(last_out - first_out), 32'd9);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            imm_src   = 3'($urandom_range(0, 7));
            imm       = rand_imm();
            base      = 25'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rand_drained", 32'(sb.size()), 32'd0);

        // Reset with two items in flight
        out_ready = 1'b0;
        send(3'd3, 32'h10, 25'h1);
        send(3'd7, 32'h20, 25'h2);
        pulse_reset();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_instr_hi", 32'(instr_hi), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;

        // Three erroneous outputs
        out_ready = 1'b1;
        send(3'd7, 32'h0, 25'h3);
        send(3'd2, 32'h1, 25'h0);
        send(3'd3, 32'h1000, 25'h0);
        repeat (4) @(posedge clk);
        #1;
        check("errcnt_three", 32'(err_count), CNT_EN ? 32'd3 : 32'd0);
        pulse_reset();
        @(negedge clk);
        check("errcnt_cleared", 32'(err_count), 32'd0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_encode.md
Name: imm_encode

Overview:
- Inverse of the core's immediate-extension stage: packs a 32-bit immediate into RV32I instruction bits [31:7] for a selected format.
- Merges the packed immediate with caller-supplied non-immediate fields and flags out-of-range and misaligned values.
- Sits in the debug/self-test program generator ahead of instruction-memory writes.
- 2-stage pipeline with valid/ready on both sides.

Parameters:
- none (widths fixed by the RV32I encoding)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
imm_src  input  3  format: 000 U, 001 S, 010 B, 011 I, 100 J, others illegal
imm  input  32  immediate value (two's complement)
base  input  25  template for instr bits [31:7]; supplies rd/rs1/rs2/funct3 bits
out_valid  output  1  result valid
out_ready  input  1  downstream accepts when out_valid && out_ready
instr_hi  output  25  encoded instr bits [31:7]
range_err  output  1  imm not representable in format
align_err  output  1  imm[0]=1 for B or J
fmt_err  output  1  imm_src illegal
err_count  output  8  see Optional Feature

Behaviour:
Encoding (bit i below = instr_hi[i]; unlisted bits come from base):
- U: [24:5]=imm[31:12]. range_err if imm[11:0]!=0.
- S: [24:18]=imm[11:5]; [4:0]=imm[4:0]. range_err unless imm[31:11] all equal.
- B: [24]=imm[12]; [23:18]=imm[10:5]; [4:1]=imm[4:1]; [0]=imm[11]. range_err unless imm[31:12] all equal. align_err if imm[0].
- I: [24:13]=imm[11:0]. range_err unless imm[31:11] all equal.
- J: [24]=imm[20]; [23:14]=imm[10:1]; [13]=imm[11]; [12:5]=imm[19:12]. range_err unless imm[31:20] all equal. align_err if imm[0].
- Illegal imm_src: instr_hi=base, fmt_err=1, range_err=align_err=0.
- Encoding on error: still computed from low bits, i.e. truncation, no saturation.

Pipeline:
- Stage 1 registers inputs and computes encoding plus error flags.
- Stage 2 is the output register driving instr_hi and the error outputs.
- s1_adv = !s2_valid || out_ready.
- in_ready = !s1_valid || s1_adv. Combinational from registered state and out_ready; no path from in_valid.
- Latency 2 cycles from acceptance to out_valid with no backpressure; throughput 1 per cycle.
- Up to 2 items buffered. With out_ready held low, in_ready drops after 2 acceptances.
- While out_valid && !out_ready: instr_hi and all error flags held stable.
- Simultaneous accept on input and output in the same cycle is legal; no bubble inserted.

Reset:
- reset=1 at a clk edge clears s1_valid, s2_valid, and err_count.
- Reset values: out_valid=0, instr_hi=0, range_err=0, align_err=0, fmt_err=0, in_ready=1 in the cycle after reset.
- Reset mid-operation discards in-flight items; no partial output.

Optional Feature:
IMM_ENCODE_ERRCNT_EN
- Defined: err_count increments by 1 on each output handshake whose range_err|align_err|fmt_err is 1; saturates at 8'hFF; cleared only by reset.
- Undefined: err_count tied to 8'h00; no counter flops.

Test Plan:
- I: imm=32'hFFFFF800, base=25'h0000ABC -> instr_hi=25'h1000ABC, no errors, out_valid 2 cycles after accept. Then imm=32'h00000800 -> range_err=1.
- B: imm=32'hFFFFFFFC, base=0 -> instr_hi=25'h1FC001D, no errors. Then imm=32'h00000003 -> align_err=1.
- U: imm=32'h12345000, base=25'h1F -> instr_hi=25'h2468BF. J: imm=2, base=0 -> instr_hi=25'h0004000. imm_src=3'b111, base=25'h155 -> instr_hi=25'h155, fmt_err=1.
- Backpressure: out_ready=0, in_valid=1 for 4 cycles with distinct imms -> exactly 2 accepted, in_ready=0, instr_hi stable. Raise out_ready -> both emitted in order, then in_ready=1.
- Streaming: out_ready=1, 10 back-to-back requests -> 10 outputs on consecutive cycles, in order, in_ready never low.
- Reset while 2 items in flight -> next cycle out_valid=0, instr_hi=0. With IMM_ENCODE_ERRCNT_EN, 3 erroneous outputs -> err_count=3; count reset to 0. Without the macro, err_count=0 throughout.
